// File: rtl/mem_arb_if.sv
// Bundle of the IFU, LSU and downstream memory handshakes that meet at mem_arb.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_arb_if;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;

  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;

  logic        mem_reqValid;
  logic        mem_reqReady;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;

  modport slave (
    input  ifu_reqValid, ifu_addr,
    output ifu_respValid, ifu_rdata,
    input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_respValid, lsu_rdata,
    output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    input  mem_reqReady, mem_respValid, mem_rdata
  );

  modport master (
    output ifu_reqValid, ifu_addr,
    input  ifu_respValid, ifu_rdata,
    output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_respValid, lsu_rdata,
    input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    output mem_reqReady, mem_respValid, mem_rdata
  );
endinterface

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one transaction
// in flight, with a response timeout that forces a zero-data reply.
module mem_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic     clock,
  input  logic     reset,
  mem_arb_if.slave bus,
  output logic     busy,
  output logic     timeout_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;
  typedef enum logic {OwnIfu, OwnLsu} owner_e;

  localparam logic [15:0] TcntLast = 16'(TIMEOUT - 1);

  state_e      state_q;
  owner_e      owner_q;
  owner_e      last_grant_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        wen_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] rdata_q;
  logic [15:0] tcnt_q;
  logic        timeout_err_q;

  logic grant;
  logic pick_lsu;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant    = bus.ifu_reqValid | bus.lsu_reqValid;
    pick_lsu = bus.lsu_reqValid & (~bus.ifu_reqValid | (last_grant_q == OwnIfu));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      owner_q       <= OwnIfu;
      last_grant_q  <= OwnLsu;
      addr_q        <= '0;
      size_q        <= '0;
      wen_q         <= 1'b0;
      wdata_q       <= '0;
      wmask_q       <= '0;
      rdata_q       <= '0;
      tcnt_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant) begin
            state_q <= StReq;
            if (pick_lsu) begin
              owner_q      <= OwnLsu;
              last_grant_q <= OwnLsu;
              addr_q       <= bus.lsu_addr;
              size_q       <= bus.lsu_size;
              wen_q        <= bus.lsu_wen;
              wdata_q      <= bus.lsu_wdata;
              wmask_q      <= bus.lsu_wmask;
            end else begin
              owner_q      <= OwnIfu;
              last_grant_q <= OwnIfu;
              addr_q       <= bus.ifu_addr;
              size_q       <= 2'd2;
              wen_q        <= 1'b0;
              wdata_q      <= '0;
              wmask_q      <= '0;
            end
          end
        end
        StReq: begin
          if (bus.mem_reqReady) begin
            state_q <= StWait;
            tcnt_q  <= '0;
          end
        end
        StWait: begin
          tcnt_q <= tcnt_q + 16'd1;
          // A response on the last timeout cycle still wins over the timeout.
          if (bus.mem_respValid) begin
            rdata_q <= bus.mem_rdata;
            state_q <= StResp;
          end else if (tcnt_q == TcntLast) begin
            rdata_q       <= '0;
            timeout_err_q <= 1'b1;
            state_q       <= StResp;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_reqValid  = (state_q == StReq);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_size      = size_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
  assign bus.ifu_respValid = (state_q == StResp) && (owner_q == OwnIfu);
  assign bus.lsu_respValid = (state_q == StResp) && (owner_q == OwnLsu);
  assign bus.ifu_rdata     = rdata_q;
  assign bus.lsu_rdata     = rdata_q;
  assign busy              = (state_q != StIdle);
  assign timeout_err       = timeout_err_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed vector table, hand-written reset and
// round-robin sequences, and randomized traffic against a round-robin/latency model.
module tb_mem_arb;
  localparam int TO = 8;

  logic clock = 1'b0;
  logic reset;
  logic busy;
  logic timeout_err;

  mem_arb_if bus ();

  mem_arb #(.TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Memory responder knobs (set by the test) and observations (set by the responder).
  int          cur_rs;
  int          cur_ps;
  logic [31:0] cur_data;
  int          phase = 0;
  int          wcnt = 0;
  int          req_hi = 0;
  bit          unstable = 0;
  logic [31:0] acc_addr, acc_wdata;
  logic [1:0]  acc_size;
  logic        acc_wen;
  logic [3:0]  acc_wmask;

  bit te_exp;
  bit last_lsu;

  typedef struct {
    bit          lsu;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          rs;
    int          ps;
    logic [31:0] data;
    int          exp_cycle;
    logic [31:0] exp_rdata;
    bit          exp_te;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory: holds ready low for cur_rs REQ cycles, then answers cur_ps WAIT cycles
  // later; cur_ps >= TO means it never answers.
  initial begin
    bus.mem_reqReady  = 1'b0;
    bus.mem_respValid = 1'b0;
    bus.mem_rdata     = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.mem_respValid = 1'b0;
      bus.mem_reqReady  = 1'b0;
      bus.mem_rdata     = $urandom;
      if (phase == 0) begin
        if (bus.mem_reqValid) begin
          req_hi++;
          if (req_hi == 1) begin
            acc_addr  = bus.mem_addr;
            acc_size  = bus.mem_size;
            acc_wen   = bus.mem_wen;
            acc_wdata = bus.mem_wdata;
            acc_wmask = bus.mem_wmask;
          end else if ({acc_addr, acc_size, acc_wen, acc_wdata, acc_wmask} !==
                       {bus.mem_addr, bus.mem_size, bus.mem_wen, bus.mem_wdata, bus.mem_wmask}) begin
            unstable = 1'b1;
          end
          if (req_hi > cur_rs) begin
            bus.mem_reqReady = 1'b1;
            phase = 1;
            wcnt  = 0;
          end
        end
      end else begin
        if (cur_ps >= TO) begin
          phase = 0;
        end else if (wcnt == cur_ps) begin
          bus.mem_respValid = 1'b1;
          bus.mem_rdata     = cur_data;
          phase = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic scramble(input bit lsu);
    if (lsu) begin
      bus.lsu_addr  = $urandom;
      bus.lsu_size  = 2'($urandom_range(3));
      bus.lsu_wen   = 1'($urandom_range(1));
      bus.lsu_wdata = $urandom;
      bus.lsu_wmask = 4'($urandom_range(15));
    end else begin
      bus.ifu_addr = $urandom;
    end
  endtask

  // Called at the falling edge of an IDLE cycle (cycle 0) with requests already set.
  task automatic txn(input string tag, input bit exp_lsu, input int e_cycle,
                     input logic [31:0] e_rdata);
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_size;
    logic        e_wen;
    logic [3:0]  e_wmask;
    int n;
    bit seen;
    if (exp_lsu) begin
      e_addr = bus.lsu_addr; e_size = bus.lsu_size; e_wen = bus.lsu_wen;
      e_wdata = bus.lsu_wdata; e_wmask = bus.lsu_wmask;
    end else begin
      e_addr = bus.ifu_addr; e_size = 2'd2; e_wen = 1'b0; e_wdata = '0; e_wmask = '0;
    end
    req_hi = 0; unstable = 1'b0; n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (n == 1) scramble(exp_lsu);
      seen = bus.ifu_respValid | bus.lsu_respValid;
    end
    chk({tag, ".resp_seen"}, 32'(seen), 32'd1);
    chk({tag, ".ifu_resp"}, 32'(bus.ifu_respValid), 32'(!exp_lsu));
    chk({tag, ".lsu_resp"}, 32'(bus.lsu_respValid), 32'(exp_lsu));
    chk({tag, ".cycle"}, 32'(n), 32'(e_cycle));
    chk({tag, ".rdata"}, exp_lsu ? bus.lsu_rdata : bus.ifu_rdata, e_rdata);
    chk({tag, ".mem_addr"}, acc_addr, e_addr);
    chk({tag, ".mem_size"}, 32'(acc_size), 32'(e_size));
    chk({tag, ".mem_wen"}, 32'(acc_wen), 32'(e_wen));
    chk({tag, ".mem_wdata"}, acc_wdata, e_wdata);
    chk({tag, ".mem_wmask"}, 32'(acc_wmask), 32'(e_wmask));
    chk({tag, ".req_cycles"}, 32'(req_hi), 32'(cur_rs + 1));
    chk({tag, ".payload_stable"}, 32'(unstable), 32'd0);
    if (exp_lsu) bus.lsu_reqValid = 1'b0;
    else bus.ifu_reqValid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk({tag, ".pulse_end"}, 32'(bus.ifu_respValid | bus.lsu_respValid), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(te_exp));
    last_lsu = exp_lsu;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //              lsu addr          sz   wen wdata        wm   rs ps data          cyc rdata         te
    vecs[0] = '{1'b0, 32'h8000_0000, 2'd0, 1'b0, 32'h0,        4'h0, 0, 0,  32'h0000_0413, 3,  32'h0000_0413, 1'b0};
    vecs[1] = '{1'b1, 32'h8000_1004, 2'd0, 1'b1, 32'h0000_00AB, 4'h1, 3, 0,  32'hDEAD_BEEF, 6,  32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h8000_2002, 2'd1, 1'b0, 32'h0000_0055, 4'h3, 1, 2,  32'hCAFE_1234, 6,  32'hCAFE_1234, 1'b0};
    vecs[3] = '{1'b1, 32'h8000_3000, 2'd2, 1'b0, 32'h0,        4'h0, 0, 99, 32'h1111_2222, 10, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 32'h8000_0010, 2'd0, 1'b0, 32'h0,        4'h0, 0, 7,  32'h1234_5678, 10, 32'h1234_5678, 1'b1};
    vecs[5] = '{1'b0, 32'h8000_0014, 2'd0, 1'b0, 32'h0,        4'h0, 2, 1,  32'h0010_0073, 6,  32'h0010_0073, 1'b1};

    reset = 1'b1;
    bus.ifu_reqValid = 1'b0; bus.ifu_addr = '0;
    bus.lsu_reqValid = 1'b0; bus.lsu_addr = '0; bus.lsu_size = '0; bus.lsu_wen = 1'b0;
    bus.lsu_wdata = '0; bus.lsu_wmask = '0;
    cur_rs = 0; cur_ps = 0; cur_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    te_exp = 1'b0;
    last_lsu = 1'b1;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.timeout_err", 32'(timeout_err), 32'd0);
    chk("reset.ctrl", 32'({bus.mem_reqValid, bus.ifu_respValid, bus.lsu_respValid}), 32'd0);
    chk("reset.mem_addr", bus.mem_addr, 32'd0);
    chk("reset.payload", 32'({bus.mem_size, bus.mem_wen, bus.mem_wmask}), 32'd0);
    chk("reset.mem_wdata", bus.mem_wdata, 32'd0);
    chk("reset.rdata", bus.ifu_rdata | bus.lsu_rdata, 32'd0);

    // Both requesters held: IFU wins the first tie, then strict alternation.
    cur_rs = 0; cur_ps = 0;
    bus.ifu_addr = 32'h0000_1000; bus.ifu_reqValid = 1'b1;
    bus.lsu_addr = 32'h0000_2000; bus.lsu_size = 2'd2; bus.lsu_wen = 1'b1;
    bus.lsu_wdata = 32'h0BAD_F00D; bus.lsu_wmask = 4'hF; bus.lsu_reqValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cur_data = 32'hA5A5_0000 + 32'(i);
      txn($sformatf("rr%0d", i), i[0], 3, 32'hA5A5_0000 + 32'(i));
      if (i < 3) begin
        if (i[0]) begin
          bus.lsu_addr = 32'h0000_2000 + 32'(i); bus.lsu_reqValid = 1'b1;
        end else begin
          bus.ifu_addr = 32'h0000_1000 + 32'(i); bus.ifu_reqValid = 1'b1;
        end
      end
    end

    for (int i = 0; i < 6; i++) begin
      cur_rs = vecs[i].rs; cur_ps = vecs[i].ps; cur_data = vecs[i].data;
      if (vecs[i].lsu) begin
        bus.lsu_addr = vecs[i].addr; bus.lsu_size = vecs[i].size; bus.lsu_wen = vecs[i].wen;
        bus.lsu_wdata = vecs[i].wdata; bus.lsu_wmask = vecs[i].wmask; bus.lsu_reqValid = 1'b1;
      end else begin
        bus.ifu_addr = vecs[i].addr; bus.ifu_reqValid = 1'b1;
      end
      te_exp = vecs[i].exp_te;
      txn($sformatf("vec%0d", i), vecs[i].lsu, vecs[i].exp_cycle, vecs[i].exp_rdata);
    end

    // Reset while waiting on a silent memory: transaction is abandoned.
    cur_rs = 0; cur_ps = 99;
    bus.ifu_addr = 32'h8000_0100; bus.ifu_reqValid = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_wait.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    bus.ifu_reqValid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    te_exp = 1'b0;
    last_lsu = 1'b1;
    chk("rst_wait.busy", 32'(busy), 32'd0);
    chk("rst_wait.mem_reqValid", 32'(bus.mem_reqValid), 32'd0);
    chk("rst_wait.timeout_err", 32'(timeout_err), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rst_wait.no_resp%0d", i), 32'(bus.ifu_respValid | bus.lsu_respValid), 32'd0);
      @(posedge clock);
      @(negedge clock);
    end
    cur_rs = 1; cur_ps = 0; cur_data = 32'h0000_0093;
    bus.ifu_addr = 32'h8000_0200; bus.ifu_reqValid = 1'b1;
    txn("rst_wait.after", 1'b0, 4, 32'h0000_0093);

    // Random traffic: winner from the round-robin rule, latency from the stall counts.
    for (int i = 0; i < 40; i++) begin
      bit exp_lsu;
      int e_cycle;
      if (!bus.ifu_reqValid && ($urandom_range(1) == 1)) begin
        bus.ifu_addr = $urandom; bus.ifu_reqValid = 1'b1;
      end
      if (!bus.lsu_reqValid && ($urandom_range(1) == 1)) begin
        bus.lsu_addr = $urandom; bus.lsu_size = 2'($urandom_range(2));
        bus.lsu_wen = 1'($urandom_range(1)); bus.lsu_wdata = $urandom;
        bus.lsu_wmask = 4'($urandom_range(15)); bus.lsu_reqValid = 1'b1;
      end
      if (!bus.ifu_reqValid && !bus.lsu_reqValid) begin
        bus.ifu_addr = $urandom; bus.ifu_reqValid = 1'b1;
      end
      exp_lsu = (bus.ifu_reqValid && bus.lsu_reqValid) ? !last_lsu : bus.lsu_reqValid;
      cur_rs = $urandom_range(3);
      cur_ps = $urandom_range(TO + 1);
      cur_data = $urandom;
      if (cur_ps >= TO) begin
        te_exp = 1'b1;
        e_cycle = 2 + cur_rs + TO;
      end else begin
        e_cycle = 3 + cur_rs + cur_ps;
      end
      txn($sformatf("rnd%0d", i), exp_lsu, e_cycle, (cur_ps >= TO) ? 32'd0 : cur_data);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
